bp_be_dcache_resp_checker: RTL and testbench
============================================

BP_BE_DCACHE_RESP_CHECKER -- requirements
Module: bp_be_dcache_resp_checker

Interface
REQ-001 SHALL have parameter data_width_p, default 64, response/expected data width in bits.
REQ-002 SHALL have parameter els_p, default 8, response buffer depth in entries.
REQ-003 SHALL have parameter cnt_width_p, default 16, width of match/mismatch/idle counters.
REQ-004 SHALL have parameter timeout_p, default 65535, idle cycles in RUN before timeout fail.
REQ-005 SHALL have parameter extra_window_p, default 4, cycles watched for surplus responses after the last compare.
REQ-006 SHALL have port clk_i  input  1  clock.
REQ-007 SHALL have port reset_i  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port resp_v_i  input  1  dcache load response valid.
REQ-009 SHALL have port resp_data_i  input  data_width_p  dcache load response data.
REQ-010 SHALL have port resp_ready_o  output  1  buffer can accept a response.
REQ-011 SHALL have port exp_v_i  input  1  expected value available.
REQ-012 SHALL have port exp_data_i  input  data_width_p  expected data.
REQ-013 SHALL have port exp_mask_i  input  data_width_p  bit mask; 1 = bit compared.
REQ-014 SHALL have port exp_last_i  input  1  final expected value of the test.
REQ-015 SHALL have port exp_yumi_o  output  1  expected value consumed this cycle.
REQ-016 SHALL have ports match_cnt_o and mismatch_cnt_o, each  output  cnt_width_p  compare counts.
REQ-017 SHALL have port err_v_o  output  1  one-cycle pulse on mismatch; err_exp_o/err_got_o  output  data_width_p  hold the most recent mismatching pair.
REQ-018 SHALL have ports pass_o, fail_o, timeout_o, overflow_o, extra_o  output  1 each  sticky status.

Function
REQ-019 SHALL buffer accepted responses in FIFO order; resp_ready_o = buffer not full; accept on resp_v_i & resp_ready_o.
REQ-020 SHALL not bypass: a response accepted in cycle N is compared no earlier than cycle N+1.
REQ-021 SHALL compare when state=RUN, buffer non-empty and exp_v_i; exp_yumi_o asserts and buffer pops in the same cycle.
REQ-022 SHALL declare mismatch iff ((head ^ exp_data_i) & exp_mask_i) != 0; all-zero mask always matches.
REQ-023 SHALL increment match_cnt_o or mismatch_cnt_o once per compare, saturating at all-ones.
REQ-024 SHALL, on mismatch, pulse err_v_o the following cycle and register err_exp_o/err_got_o (unmasked values).
REQ-025 SHALL use states RUN, DRAIN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-026 SHALL move RUN->DRAIN on a compare with exp_last_i=1, clearing a window counter.
REQ-027 SHALL, in DRAIN, go FAIL with extra_o=1 if the buffer is non-empty or a response is accepted; after extra_window_p cycles go PASS if mismatch_cnt_o=0, else FAIL.
REQ-028 SHALL keep an idle counter in RUN, cleared on each compare; at timeout_p go FAIL with timeout_o=1.
REQ-029 SHALL set overflow_o and go FAIL if resp_v_i=1 while the buffer is full; dropped data is not buffered.
REQ-030 SHALL keep resp_ready_o=0 when full even if a pop occurs the same cycle.
REQ-031 SHALL keep resp_ready_o=1 in DRAIN/PASS/FAIL when not full; responses in PASS/FAIL are accepted and discarded.
REQ-032 SHALL assert pass_o iff state=PASS and fail_o iff state=FAIL; never both.

Reset
REQ-033 SHALL, while reset_i=0, clear buffer, counters and sticky flags, enter RUN; all outputs 0 except resp_ready_o=0 during reset and 1 from the first cycle after release.
REQ-034 SHALL abandon an in-flight compare or drain window on mid-operation reset with no residual state.

Structure
REQ-035 SHALL take the state enum (bp_be_resp_checker_state_e) from bp_be_pkg.
REQ-036 SHALL instantiate bsg_fifo_1r1w_small (width data_width_p, els_p) as the response buffer; all other logic in this module.

Verification
REQ-037 3 responses 0x11,0x22,0x33 matched by 3 expecteds (mask all-ones, last on third) -> match_cnt_o=3, pass_o=1 four cycles after last compare.
REQ-038 Response 0xFF00 vs expected 0x00FF, mask 0xFFFF -> err_v_o pulse, err_got_o=0xFF00, err_exp_o=0x00FF, fail_o=1 after drain.
REQ-039 Same pair with mask 0x0 -> match_cnt_o=1, no err_v_o, pass_o=1.
REQ-040 9 back-to-back responses, exp_v_i=0 -> resp_ready_o=0 after 8, ninth valid sets overflow_o=1, fail_o=1.
REQ-041 Last compare then one extra response 2 cycles later -> extra_o=1, fail_o=1, pass_o never set.
REQ-042 No stimulus, timeout_p=100 -> timeout_o=1, fail_o=1 at cycle 100; reset_i low mid-test returns all outputs to 0.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared back-end types for the dcache response checker.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_rc_run   = 2'd0,
    e_rc_drain = 2'd1,
    e_rc_pass  = 2'd2,
    e_rc_fail  = 2'd3
  } bp_be_resp_checker_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO with valid/ready input and valid/yumi output.
// Written data becomes visible at the head no earlier than the next cycle.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               push, pop;

  // Ready ignores a same-cycle pop so a full buffer never accepts.
  assign ready_o = (count_q != cnt_w'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + cnt_w'(push) - cnt_w'(pop);
    if (push) wr_ptr_d = (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_be_dcache_resp_checker.sv
// Compares buffered dcache load responses against an expected-value stream,
// tracking match/mismatch counts and sticky pass/fail/timeout/overflow/extra status.
module bp_be_dcache_resp_checker #(
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned els_p          = 8,
  parameter int unsigned cnt_width_p    = 16,
  parameter int unsigned timeout_p      = 65535,
  parameter int unsigned extra_window_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    resp_v_i,
  input  logic [data_width_p-1:0] resp_data_i,
  output logic                    resp_ready_o,
  input  logic                    exp_v_i,
  input  logic [data_width_p-1:0] exp_data_i,
  input  logic [data_width_p-1:0] exp_mask_i,
  input  logic                    exp_last_i,
  output logic                    exp_yumi_o,
  output logic [cnt_width_p-1:0]  match_cnt_o,
  output logic [cnt_width_p-1:0]  mismatch_cnt_o,
  output logic                    err_v_o,
  output logic [data_width_p-1:0] err_exp_o,
  output logic [data_width_p-1:0] err_got_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic                    timeout_o,
  output logic                    overflow_o,
  output logic                    extra_o
);

  import bp_be_pkg::*;

  localparam int unsigned win_w = (extra_window_p > 1) ? $clog2(extra_window_p) : 1;

  bp_be_resp_checker_state_e state_q, state_d;

  logic                    fifo_ready, fifo_v, fifo_push_v;
  logic [data_width_p-1:0] fifo_data;
  logic                    accept, overflow_c, compare, mismatch_c;

  logic [cnt_width_p-1:0]  match_q, match_d, mismatch_q, mismatch_d, idle_q, idle_d;
  logic [win_w-1:0]        win_q, win_d;
  logic                    timeout_q, timeout_d, overflow_q, overflow_d, extra_q, extra_d;
  logic                    err_v_q;
  logic [data_width_p-1:0] err_exp_q, err_got_q;

  // Only RUN/DRAIN keep responses; PASS/FAIL accept and discard them.
  assign fifo_push_v = resp_v_i & ((state_q == e_rc_run) | (state_q == e_rc_drain));

  bsg_fifo_1r1w_small #(
    .width_p(data_width_p),
    .els_p  (els_p)
  ) resp_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (fifo_push_v),
    .ready_o(fifo_ready),
    .data_i (resp_data_i),
    .v_o    (fifo_v),
    .data_o (fifo_data),
    .yumi_i (compare)
  );

  assign resp_ready_o = fifo_ready & reset_i;
  assign accept       = resp_v_i & resp_ready_o;
  assign overflow_c   = resp_v_i & ~fifo_ready;
  assign compare      = (state_q == e_rc_run) & fifo_v & exp_v_i;
  assign mismatch_c   = |((fifo_data ^ exp_data_i) & exp_mask_i);
  assign exp_yumi_o   = compare;

  // Next-state and sticky-flag logic.
  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    win_d      = win_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q | overflow_c;
    extra_d    = extra_q;
    case (state_q)
      e_rc_run: begin
        idle_d = compare ? '0 : idle_q + 1'b1;
        if (overflow_c) begin
          state_d = e_rc_fail;
        end else if (compare & exp_last_i) begin
          state_d = e_rc_drain;
          win_d   = '0;
        end else if (!compare && (idle_q == cnt_width_p'(timeout_p - 1))) begin
          state_d   = e_rc_fail;
          timeout_d = 1'b1;
        end
      end
      e_rc_drain: begin
        if (overflow_c) begin
          state_d = e_rc_fail;
        end else if (fifo_v | accept) begin
          state_d = e_rc_fail;
          extra_d = 1'b1;
        end else if (win_q == win_w'(extra_window_p - 1)) begin
          state_d = (mismatch_q == '0) ? e_rc_pass : e_rc_fail;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      e_rc_pass: state_d = e_rc_pass;
      e_rc_fail: state_d = e_rc_fail;
      default:   state_d = e_rc_run;
    endcase
  end

  // Saturating compare counters.
  always_comb begin
    match_d    = match_q;
    mismatch_d = mismatch_q;
    if (compare && !mismatch_c && !(&match_q))   match_d    = match_q + 1'b1;
    if (compare &&  mismatch_c && !(&mismatch_q)) mismatch_d = mismatch_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= e_rc_run;
      match_q    <= '0;
      mismatch_q <= '0;
      idle_q     <= '0;
      win_q      <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      extra_q    <= 1'b0;
      err_v_q    <= 1'b0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      idle_q     <= idle_d;
      win_q      <= win_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      extra_q    <= extra_d;
      err_v_q    <= compare & mismatch_c;
      if (compare & mismatch_c) begin
        err_exp_q <= exp_data_i;
        err_got_q <= fifo_data;
      end
    end
  end

  assign match_cnt_o    = match_q;
  assign mismatch_cnt_o = mismatch_q;
  assign err_v_o        = err_v_q;
  assign err_exp_o      = err_exp_q;
  assign err_got_o      = err_got_q;
  assign pass_o         = (state_q == e_rc_pass);
  assign fail_o         = (state_q == e_rc_fail);
  assign timeout_o      = timeout_q;
  assign overflow_o     = overflow_q;
  assign extra_o        = extra_q;

endmodule

// File: tb/tb_bp_be_dcache_resp_checker.sv
// Directed bench for bp_be_dcache_resp_checker with hand-computed expectations.
module tb_bp_be_dcache_resp_checker;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          resp_v_i;
  logic [DW-1:0] resp_data_i;
  logic          resp_ready_o;
  logic          exp_v_i;
  logic [DW-1:0] exp_data_i;
  logic [DW-1:0] exp_mask_i;
  logic          exp_last_i;
  logic          exp_yumi_o;
  logic [CW-1:0] match_cnt_o, mismatch_cnt_o;
  logic          err_v_o;
  logic [DW-1:0] err_exp_o, err_got_o;
  logic          pass_o, fail_o, timeout_o, overflow_o, extra_o;

  int n_checks = 0;
  int n_errors = 0;

  bp_be_dcache_resp_checker #(
    .data_width_p  (DW),
    .els_p         (8),
    .cnt_width_p   (CW),
    .timeout_p     (100),
    .extra_window_p(4)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .resp_v_i      (resp_v_i),
    .resp_data_i   (resp_data_i),
    .resp_ready_o  (resp_ready_o),
    .exp_v_i       (exp_v_i),
    .exp_data_i    (exp_data_i),
    .exp_mask_i    (exp_mask_i),
    .exp_last_i    (exp_last_i),
    .exp_yumi_o    (exp_yumi_o),
    .match_cnt_o   (match_cnt_o),
    .mismatch_cnt_o(mismatch_cnt_o),
    .err_v_o       (err_v_o),
    .err_exp_o     (err_exp_o),
    .err_got_o     (err_got_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o),
    .overflow_o    (overflow_o),
    .extra_o       (extra_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    resp_v_i    = 1'b0;
    resp_data_i = '0;
    exp_v_i     = 1'b0;
    exp_data_i  = '0;
    exp_mask_i  = '0;
    exp_last_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b0;
    repeat (2) step();
    reset_i = 1'b1;
  endtask

  task automatic push_resp(input logic [63:0] d);
    resp_v_i    = 1'b1;
    resp_data_i = d;
    step();
    resp_v_i    = 1'b0;
  endtask

  // One compare against the head; returns after the compare edge.
  task automatic do_compare(input logic [63:0] d, input logic [63:0] m, input logic last, input string tag);
    exp_v_i    = 1'b1;
    exp_data_i = d;
    exp_mask_i = m;
    exp_last_i = last;
    #1;
    check(tag, 64'(exp_yumi_o), 64'd1);
    step();
    exp_v_i    = 1'b0;
    exp_last_i = 1'b0;
  endtask

  initial begin
    logic [63:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;

    // Reset values while held and right after release
    idle_inputs();
    reset_i = 1'b0;
    #12;
    check("rst_ready", 64'(resp_ready_o), 64'd0);
    check("rst_pass",  64'(pass_o), 64'd0);
    check("rst_fail",  64'(fail_o), 64'd0);
    check("rst_match", 64'(match_cnt_o), 64'd0);
    check("rst_errv",  64'(err_v_o), 64'd0);
    check("rst_yumi",  64'(exp_yumi_o), 64'd0);
    do_reset();
    #1;
    check("rel_ready", 64'(resp_ready_o), 64'd1);

    // Three matching responses, pass four cycles after the last compare
    do_reset();
    for (int i = 0; i < 3; i++) push_resp(vals[i]);
    for (int i = 0; i < 3; i++) do_compare(vals[i], {64{1'b1}}, (i == 2), "t1_yumi");
    check("t1_match", 64'(match_cnt_o), 64'd3);
    repeat (3) step();
    check("t1_pass_early", 64'(pass_o), 64'd0);
    step();
    check("t1_pass", 64'(pass_o), 64'd1);
    check("t1_fail", 64'(fail_o), 64'd0);

    // Masked mismatch
    do_reset();
    push_resp(64'hFF00);
    do_compare(64'h00FF, 64'hFFFF, 1'b1, "t2_yumi");
    check("t2_errv",  64'(err_v_o), 64'd1);
    check("t2_got",   err_got_o, 64'hFF00);
    check("t2_exp",   err_exp_o, 64'h00FF);
    check("t2_mmcnt", 64'(mismatch_cnt_o), 64'd1);
    step();
    check("t2_errv_pulse", 64'(err_v_o), 64'd0);
    repeat (3) step();
    check("t2_fail", 64'(fail_o), 64'd1);
    check("t2_pass", 64'(pass_o), 64'd0);

    // Same pair, zero mask always matches
    do_reset();
    push_resp(64'hFF00);
    do_compare(64'h00FF, 64'h0, 1'b1, "t3_yumi");
    check("t3_match", 64'(match_cnt_o), 64'd1);
    check("t3_errv",  64'(err_v_o), 64'd0);
    repeat (4) step();
    check("t3_pass", 64'(pass_o), 64'd1);

    // Full buffer stays not-ready during a same-cycle pop
    do_reset();
    for (int i = 0; i < 8; i++) push_resp(64'(i));
    exp_v_i = 1'b1; exp_mask_i = '0; exp_last_i = 1'b0;
    #1;
    check("t5_yumi_full",  64'(exp_yumi_o), 64'd1);
    check("t5_ready_full", 64'(resp_ready_o), 64'd0);
    step();
    exp_v_i = 1'b0;
    check("t5_ready_after", 64'(resp_ready_o), 64'd1);
    check("t5_match", 64'(match_cnt_o), 64'd1);

    // Overflow on the ninth back-to-back response
    do_reset();
    resp_v_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      resp_data_i = 64'(i + 1);
      #1;
      check("t4_ready", 64'(resp_ready_o), 64'd1);
      step();
    end
    resp_data_i = 64'd9;
    check("t4_ready_full", 64'(resp_ready_o), 64'd0);
    step();
    resp_v_i = 1'b0;
    check("t4_overflow", 64'(overflow_o), 64'd1);
    check("t4_fail", 64'(fail_o), 64'd1);

    // Surplus response two cycles after the last compare
    do_reset();
    push_resp(64'h5);
    do_compare(64'h5, {64{1'b1}}, 1'b1, "t6_yumi");
    step();
    check("t6_mid", 64'(fail_o), 64'd0);
    push_resp(64'h6);
    check("t6_extra", 64'(extra_o), 64'd1);
    check("t6_fail",  64'(fail_o), 64'd1);
    repeat (4) step();
    check("t6_pass_never", 64'(pass_o), 64'd0);
    check("t6_ready_fail", 64'(resp_ready_o), 64'd1);

    // Timeout after 100 idle cycles, then mid-test reset
    do_reset();
    repeat (99) step();
    check("t7_fail_early", 64'(fail_o), 64'd0);
    step();
    check("t7_timeout", 64'(timeout_o), 64'd1);
    check("t7_fail",    64'(fail_o), 64'd1);
    reset_i = 1'b0;
    #1;
    check("t7_rst_timeout", 64'(timeout_o), 64'd0);
    check("t7_rst_fail",    64'(fail_o), 64'd0);
    check("t7_rst_ready",   64'(resp_ready_o), 64'd0);
    reset_i = 1'b1;

    // Reset mid-drain leaves no residual state
    do_reset();
    push_resp(64'h7);
    do_compare(64'h8, {64{1'b1}}, 1'b1, "t8_yumi");
    step();
    reset_i = 1'b0;
    #1;
    check("t8_rst_mm",   64'(mismatch_cnt_o), 64'd0);
    check("t8_rst_got",  err_got_o, 64'd0);
    reset_i = 1'b1;
    repeat (6) step();
    check("t8_no_pass", 64'(pass_o), 64'd0);
    check("t8_no_fail", 64'(fail_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
